// File: rtl/counter_monitor_pkg.sv
// Shared types and default widths for the counter monitor.
// Optional feature macro: COUNTER_MON_LOAD_ACCEPT_EN. When it is defined, a
// jump to a value whose upper bits are all zero is accepted as a nibble load.
package counter_monitor_pkg;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_LOCK_COUNT = 3;
    localparam int DEF_ERR_W      = 8;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        CLS_HOLD = 3'd0,
        CLS_UP   = 3'd1,
        CLS_DOWN = 3'd2,
        CLS_JUMP = 3'd3,
        CLS_LOAD = 3'd4
    } step_cls_e;

endpackage

// File: rtl/step_classifier.sv
// Combinational step classifier: computes bus_i - last_i (mod 2^WIDTH) and
// decodes it into HOLD / UP / DOWN / JUMP. With COUNTER_MON_LOAD_ACCEPT_EN
// defined, a jump whose target has its upper WIDTH-4 bits clear is reported
// as LOAD; the caller decides whether LOAD matters in its current state.
module step_classifier
    import counter_monitor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] bus_i,
    input  logic [WIDTH-1:0] last_i,
    output step_cls_e        cls_o
);

    logic [WIDTH-1:0] delta_s;

    assign delta_s = bus_i - last_i;

    // Decode the wrap-around delta into a step class
    always_comb begin
        cls_o = CLS_JUMP;
        if (delta_s == {WIDTH{1'b0}}) begin
            cls_o = CLS_HOLD;
        end else if (delta_s == WIDTH'(1)) begin
            cls_o = CLS_UP;
        end else if (delta_s == {WIDTH{1'b1}}) begin
            cls_o = CLS_DOWN;
        end else begin
`ifdef COUNTER_MON_LOAD_ACCEPT_EN
            if (bus_i[WIDTH-1:4] == {(WIDTH-4){1'b0}}) begin
                cls_o = CLS_LOAD;
            end else begin
                cls_o = CLS_JUMP;
            end
`else
            cls_o = CLS_JUMP;
`endif
        end
    end

endmodule

// File: rtl/counter_monitor.sv
// Receive-side monitor for a stepping counter. Tracks the observed value,
// locks after LOCK_COUNT consecutive same-direction steps and flags jumps
// seen while locked as protocol violations (saturating error count).
// Optional feature macro: COUNTER_MON_LOAD_ACCEPT_EN (nibble-load accepted
// while locked; decoded inside step_classifier).
module counter_monitor
    import counter_monitor_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int LOCK_COUNT = DEF_LOCK_COUNT,
    parameter int ERR_W      = DEF_ERR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             clr_err,
    output logic             locked,
    output logic             dir_up,
    output logic             step_err,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] last_val,
    output logic [1:0]       state
);

    localparam int STREAK_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [STREAK_W-1:0] LOCK_VAL = STREAK_W'(LOCK_COUNT);

    state_e              state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                dir_up_q, dir_up_d;
    logic                locked_q, locked_d;
    logic                step_err_q, step_err_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [WIDTH-1:0]    last_q, last_d;
    logic                viol_s;
    logic                step_up_s;
    step_cls_e           cls_s;

    step_classifier #(
        .WIDTH (WIDTH)
    ) u_cls (
        .bus_i  (bus_in),
        .last_i (last_q),
        .cls_o  (cls_s)
    );

    assign step_up_s = (cls_s == CLS_UP);

    // Next-state logic for FSM, streak, direction, last value and violation
    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        dir_up_d = dir_up_q;
        last_d   = last_q;
        viol_s   = 1'b0;
        if (sample_valid) begin
            last_d = bus_in;
            case (state_q)
                ST_EMPTY: begin
                    // first sample only seeds last_val
                    state_d  = ST_SYNC;
                    streak_d = {STREAK_W{1'b0}};
                end
                ST_SYNC: begin
                    case (cls_s)
                        CLS_UP, CLS_DOWN: begin
                            if ((streak_q != {STREAK_W{1'b0}}) && (step_up_s == dir_up_q)) begin
                                streak_d = streak_q + STREAK_W'(1);
                            end else begin
                                streak_d = STREAK_W'(1);
                                dir_up_d = step_up_s;
                            end
                            if (streak_d == LOCK_VAL) begin
                                state_d = ST_LOCKED;
                            end else begin
                                state_d = ST_SYNC;
                            end
                        end
                        CLS_HOLD: begin
                            streak_d = streak_q;
                        end
                        CLS_JUMP, CLS_LOAD: begin
                            // a jump while hunting just restarts the hunt
                            streak_d = {STREAK_W{1'b0}};
                        end
                        default: begin
                            streak_d = {STREAK_W{1'b0}};
                        end
                    endcase
                end
                ST_LOCKED: begin
                    case (cls_s)
                        CLS_HOLD, CLS_LOAD: begin
                            state_d = ST_LOCKED;
                        end
                        CLS_UP, CLS_DOWN: begin
                            // reversal is legal once locked
                            dir_up_d = step_up_s;
                        end
                        CLS_JUMP: begin
                            viol_s   = 1'b1;
                            state_d  = ST_SYNC;
                            streak_d = {STREAK_W{1'b0}};
                        end
                        default: begin
                            viol_s   = 1'b1;
                            state_d  = ST_SYNC;
                            streak_d = {STREAK_W{1'b0}};
                        end
                    endcase
                end
                default: begin
                    state_d  = ST_EMPTY;
                    streak_d = {STREAK_W{1'b0}};
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Error counter: clear wins over increment, increment saturates
    always_comb begin
        err_d = err_q;
        if (clr_err) begin
            err_d = {ERR_W{1'b0}};
        end else if (viol_s && (err_q != {ERR_W{1'b1}})) begin
            err_d = err_q + ERR_W'(1);
        end else begin
            err_d = err_q;
        end
    end

    // Registered-output next values
    always_comb begin
        step_err_d = viol_s;
        locked_d   = (state_d == ST_LOCKED);
    end

    // State and output registers, asynchronously cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            streak_q   <= {STREAK_W{1'b0}};
            dir_up_q   <= 1'b0;
            locked_q   <= 1'b0;
            step_err_q <= 1'b0;
            err_q      <= {ERR_W{1'b0}};
            last_q     <= {WIDTH{1'b0}};
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            dir_up_q   <= dir_up_d;
            locked_q   <= locked_d;
            step_err_q <= step_err_d;
            err_q      <= err_d;
            last_q     <= last_d;
        end
    end

    assign locked    = locked_q;
    assign dir_up    = dir_up_q;
    assign step_err  = step_err_q;
    assign err_count = err_q;
    assign last_val  = last_q;
    assign state     = state_q;

endmodule

// File: tb/tb_counter_monitor.sv
// Directed self-checking bench for counter_monitor (default parameters).
// Expectations follow COUNTER_MON_LOAD_ACCEPT_EN when it is defined.
module tb_counter_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_valid = 1'b0;
    logic [7:0] bus_in = 8'h00;
    logic       clr_err = 1'b0;
    logic       locked;
    logic       dir_up;
    logic       step_err;
    logic [7:0] err_count;
    logic [7:0] last_val;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    counter_monitor dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .bus_in       (bus_in),
        .clr_err      (clr_err),
        .locked       (locked),
        .dir_up       (dir_up),
        .step_err     (step_err),
        .err_count    (err_count),
        .last_val     (last_val),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // one valid sample; returns #1 after the capturing edge
    task automatic send(input logic [7:0] v, input logic clr = 1'b0);
        @(negedge clk);
        sample_valid = 1'b1;
        bus_in       = v;
        clr_err      = clr;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        clr_err      = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        sample_valid = 1'b0;
        bus_in       = 8'hA5;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_state"}, {30'd0, state}, 32'd0);
        check_eq({tag, "_locked"}, {31'd0, locked}, 32'd0);
        check_eq({tag, "_dir"}, {31'd0, dir_up}, 32'd0);
        check_eq({tag, "_serr"}, {31'd0, step_err}, 32'd0);
        check_eq({tag, "_err"}, {24'd0, err_count}, 32'd0);
        check_eq({tag, "_last"}, {24'd0, last_val}, 32'd0);
    endtask

    initial begin
        // reset values
        #12;
        check_reset_vals("rst0");
        do_reset();

        // lock on 10,11,12,13
        send(8'h10);
        check_eq("cap_state", {30'd0, state}, 32'd1);
        check_eq("cap_last", {24'd0, last_val}, 32'h10);
        check_eq("cap_locked", {31'd0, locked}, 32'd0);
        send(8'h11);
        send(8'h12);
        check_eq("lock_pre_state", {30'd0, state}, 32'd1);
        send(8'h13);
        check_eq("lock_locked", {31'd0, locked}, 32'd1);
        check_eq("lock_dir", {31'd0, dir_up}, 32'd1);
        check_eq("lock_err", {24'd0, err_count}, 32'd0);
        check_eq("lock_state", {30'd0, state}, 32'd2);

        // idle holds everything
        idle_cycle();
        check_eq("idle_state", {30'd0, state}, 32'd2);
        check_eq("idle_last", {24'd0, last_val}, 32'h13);

        // async reset mid-operation, checked before any clock edge
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("rstmid");
        @(negedge clk);
        rst = 1'b0;
        send(8'h33);
        check_eq("post_rst_state", {30'd0, state}, 32'd1);
        check_eq("post_rst_last", {24'd0, last_val}, 32'h33);
        check_eq("post_rst_serr", {31'd0, step_err}, 32'd0);

        // wrap-around and reversal while locked
        do_reset();
        send(8'hFB); send(8'hFC); send(8'hFD); send(8'hFE);
        check_eq("wrap_locked0", {31'd0, locked}, 32'd1);
        send(8'hFF);
        check_eq("wrap_ff_serr", {31'd0, step_err}, 32'd0);
        send(8'h00);
        check_eq("wrap_00_serr", {31'd0, step_err}, 32'd0);
        check_eq("wrap_00_locked", {31'd0, locked}, 32'd1);
        check_eq("wrap_00_dir", {31'd0, dir_up}, 32'd1);
        send(8'hFF);
        check_eq("wrap_rev_serr", {31'd0, step_err}, 32'd0);
        check_eq("wrap_rev_locked", {31'd0, locked}, 32'd1);
        check_eq("wrap_rev_dir", {31'd0, dir_up}, 32'd0);
        send(8'hFF);
        check_eq("hold_locked", {31'd0, locked}, 32'd1);
        check_eq("hold_err", {24'd0, err_count}, 32'd0);

        // violation: locked at 12 then jump to 40
        do_reset();
        send(8'h0F); send(8'h10); send(8'h11); send(8'h12);
        send(8'h40);
        check_eq("viol_serr", {31'd0, step_err}, 32'd1);
        check_eq("viol_err", {24'd0, err_count}, 32'd1);
        check_eq("viol_state", {30'd0, state}, 32'd1);
        check_eq("viol_locked", {31'd0, locked}, 32'd0);
        check_eq("viol_last", {24'd0, last_val}, 32'h40);
        send(8'h41);
        check_eq("viol_pulse_once", {31'd0, step_err}, 32'd0);
        // jump in SYNC is silent and restarts the streak
        send(8'h90);
        check_eq("sync_jump_serr", {31'd0, step_err}, 32'd0);
        check_eq("sync_jump_err", {24'd0, err_count}, 32'd1);
        send(8'h91); send(8'h92);
        check_eq("sync_restart_state", {30'd0, state}, 32'd1);
        send(8'h93);
        check_eq("sync_relock_state", {30'd0, state}, 32'd2);

        // load-style jump while locked
        do_reset();
        send(8'h52); send(8'h53); send(8'h54); send(8'h55);
        send(8'h07);
`ifdef COUNTER_MON_LOAD_ACCEPT_EN
        check_eq("load_serr", {31'd0, step_err}, 32'd0);
        check_eq("load_locked", {31'd0, locked}, 32'd1);
        check_eq("load_err", {24'd0, err_count}, 32'd0);
`else
        check_eq("load_serr", {31'd0, step_err}, 32'd1);
        check_eq("load_err", {24'd0, err_count}, 32'd1);
        check_eq("load_state", {30'd0, state}, 32'd1);
`endif
        check_eq("load_last", {24'd0, last_val}, 32'h07);

        // saturation: 260 lock/jump rounds alternating bases 20 and A0
        do_reset();
        send(8'h20);
        for (int i = 0; i < 260; i++) begin
            logic [7:0] base;
            base = (i % 2 == 0) ? 8'h20 : 8'hA0;
            send(base + 8'd1);
            send(base + 8'd2);
            send(base + 8'd3);
            send(base ^ 8'h80);
            if (i == 0) check_eq("sat_first", {24'd0, err_count}, 32'd1);
            if (i == 254) check_eq("sat_255", {24'd0, err_count}, 32'hFF);
        end
        check_eq("sat_final", {24'd0, err_count}, 32'hFF);
        check_eq("sat_state", {30'd0, state}, 32'd1);

        // clear together with a violation (last value is 0x20 here)
        send(8'h21); send(8'h22); send(8'h23);
        send(8'hA3, 1'b1);
        check_eq("clr_viol_err", {24'd0, err_count}, 32'd0);
        check_eq("clr_viol_serr", {31'd0, step_err}, 32'd1);
        send(8'hA4);
        check_eq("clr_after_serr", {31'd0, step_err}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
